// File: rtl/issue_pkg.sv
// Shared types for the issue stage: operand-select encodings, the bypass-source
// enum, and the per-source bypass priority function.
package issue_pkg;

  // Wide enough for any register-address width in use; callers zero-extend.
  localparam int MAX_AW = 16;

  typedef enum logic [1:0] {
    A_REG     = 2'b00,
    A_PC      = 2'b01,
    A_ZERO    = 2'b10,
    A_REG_ALT = 2'b11
  } a_sel_e;

  typedef enum logic [1:0] {
    B_REG     = 2'b00,
    B_IMM     = 2'b01,
    B_SHAMT   = 2'b10,
    B_REG_ALT = 2'b11
  } b_sel_e;

  typedef enum logic [1:0] {
    FWD_ZERO = 2'b00,
    FWD_EX   = 2'b01,
    FWD_WB   = 2'b10,
    FWD_RF   = 2'b11
  } fwd_src_e;

  // x0 first, then the younger execute result, then the commit port.
  // A load in execute has no data yet, so it never forwards from EX.
  function automatic fwd_src_e fwd_select(
    input logic [MAX_AW-1:0] rs,
    input logic              ex_we,
    input logic              ex_load,
    input logic [MAX_AW-1:0] ex_rd,
    input logic              wb_we,
    input logic [MAX_AW-1:0] wb_rd
  );
    fwd_src_e src;
    if (rs == '0)                           src = FWD_ZERO;
    else if (ex_we && !ex_load && ex_rd == rs) src = FWD_EX;
    else if (wb_we && wb_rd == rs)          src = FWD_WB;
    else                                    src = FWD_RF;
    return src;
  endfunction

endpackage

// File: rtl/issue_unit_if.sv
// Issue-stage bus: decode handshake, execute handshake, execute/commit
// observation ports, flush and the interlock indicator.
//
// Handshake rule for both in_* and out_*: a transfer happens on a rising clk
// edge where valid && ready are both high; valid may not depend on ready.
interface issue_unit_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CTRLW = 16
);
  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(XLEN);

  logic             flush;

  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_rs1;
  logic [AW-1:0]    in_rs2;
  logic [AW-1:0]    in_rd;
  logic             in_we;
  logic [1:0]       in_a_sel;
  logic [1:0]       in_b_sel;
  logic [XLEN-1:0]  in_imm;
  logic [XLEN-1:0]  in_pc;
  logic [SW-1:0]    in_shamt;
  logic [CTRLW-1:0] in_ctrl;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_op_a;
  logic [XLEN-1:0]  out_op_b;
  logic [XLEN-1:0]  out_rs2_data;
  logic [AW-1:0]    out_rd;
  logic             out_we;
  logic [XLEN-1:0]  out_imm;
  logic [XLEN-1:0]  out_pc;
  logic [CTRLW-1:0] out_ctrl;

  logic             ex_we;
  logic             ex_load;
  logic [AW-1:0]    ex_rd;
  logic [XLEN-1:0]  ex_result;

  logic             wb_we;
  logic [AW-1:0]    wb_rd;
  logic [XLEN-1:0]  wb_data;

  logic             hazard_stall;

  modport slave (
    input  flush,
    input  in_valid, in_rs1, in_rs2, in_rd, in_we, in_a_sel, in_b_sel,
           in_imm, in_pc, in_shamt, in_ctrl,
    output in_ready,
    output out_valid, out_op_a, out_op_b, out_rs2_data, out_rd, out_we,
           out_imm, out_pc, out_ctrl,
    input  out_ready,
    input  ex_we, ex_load, ex_rd, ex_result,
    input  wb_we, wb_rd, wb_data,
    output hazard_stall
  );

  modport master (
    output flush,
    output in_valid, in_rs1, in_rs2, in_rd, in_we, in_a_sel, in_b_sel,
           in_imm, in_pc, in_shamt, in_ctrl,
    input  in_ready,
    input  out_valid, out_op_a, out_op_b, out_rs2_data, out_rd, out_we,
           out_imm, out_pc, out_ctrl,
    output out_ready,
    output ex_we, ex_load, ex_rd, ex_result,
    output wb_we, wb_rd, wb_data,
    input  hazard_stall
  );
endinterface

// File: rtl/issue_regfile.sv
// Architectural register file: two combinational reads, one write port,
// asynchronous clear, x0 hardwired to zero. Not write-through.
module issue_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/issue_unit.sv
// Issue stage: one pipe register between decode and execute, operand read with
// EX/WB bypass, load-use interlock and flush.
module issue_unit
  import issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CTRLW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  issue_unit_if.slave   bus
);

  localparam int AW = $clog2(NREG);
  localparam int SW = $clog2(XLEN);

  logic             v_q, v_d;
  logic [AW-1:0]    rs1_q, rs2_q, rd_q;
  logic             we_q;
  a_sel_e           a_sel_q;
  b_sel_e           b_sel_q;
  logic [XLEN-1:0]  imm_q, pc_q;
  logic [SW-1:0]    shamt_q;
  logic [CTRLW-1:0] ctrl_q;

  logic             stall;
  logic             in_ready;
  logic             load;
  logic [XLEN-1:0]  rf_rd1, rf_rd2;
  logic [XLEN-1:0]  rs1_fwd, rs2_fwd;
  fwd_src_e         src1, src2;

  // Conservative: compares both sources regardless of operand select.
  assign stall = v_q && bus.ex_load && bus.ex_we && bus.ex_rd != '0 &&
                 (bus.ex_rd == rs1_q || bus.ex_rd == rs2_q);

  assign in_ready = !v_q || (bus.out_ready && !stall);
  assign load     = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    v_d = v_q;
    if (bus.flush)                              v_d = 1'b0;
    else if (load)                              v_d = 1'b1;
    else if (v_q && bus.out_ready && !stall)    v_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v_q     <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      a_sel_q <= A_REG;
      b_sel_q <= B_REG;
      imm_q   <= '0;
      pc_q    <= '0;
      shamt_q <= '0;
      ctrl_q  <= '0;
    end else begin
      v_q <= v_d;
      if (load) begin
        rs1_q   <= bus.in_rs1;
        rs2_q   <= bus.in_rs2;
        rd_q    <= bus.in_rd;
        we_q    <= bus.in_we;
        a_sel_q <= a_sel_e'(bus.in_a_sel);
        b_sel_q <= b_sel_e'(bus.in_b_sel);
        imm_q   <= bus.in_imm;
        pc_q    <= bus.in_pc;
        shamt_q <= bus.in_shamt;
        ctrl_q  <= bus.in_ctrl;
      end
    end
  end

  issue_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .nrst  (nrst),
    .ra1_i (rs1_q),
    .ra2_i (rs2_q),
    .rd1_o (rf_rd1),
    .rd2_o (rf_rd2),
    .we_i  (bus.wb_we),
    .wa_i  (bus.wb_rd),
    .wd_i  (bus.wb_data)
  );

  assign src1 = fwd_select(MAX_AW'(rs1_q), bus.ex_we, bus.ex_load, MAX_AW'(bus.ex_rd),
                           bus.wb_we, MAX_AW'(bus.wb_rd));
  assign src2 = fwd_select(MAX_AW'(rs2_q), bus.ex_we, bus.ex_load, MAX_AW'(bus.ex_rd),
                           bus.wb_we, MAX_AW'(bus.wb_rd));

  always_comb begin
    rs1_fwd = rf_rd1;
    case (src1)
      FWD_ZERO: rs1_fwd = '0;
      FWD_EX:   rs1_fwd = bus.ex_result;
      FWD_WB:   rs1_fwd = bus.wb_data;
      default:  rs1_fwd = rf_rd1;
    endcase
  end

  always_comb begin
    rs2_fwd = rf_rd2;
    case (src2)
      FWD_ZERO: rs2_fwd = '0;
      FWD_EX:   rs2_fwd = bus.ex_result;
      FWD_WB:   rs2_fwd = bus.wb_data;
      default:  rs2_fwd = rf_rd2;
    endcase
  end

  always_comb begin
    bus.out_op_a = rs1_fwd;
    case (a_sel_q)
      A_PC:    bus.out_op_a = pc_q;
      A_ZERO:  bus.out_op_a = '0;
      default: bus.out_op_a = rs1_fwd;
    endcase
  end

  always_comb begin
    bus.out_op_b = rs2_fwd;
    case (b_sel_q)
      B_IMM:   bus.out_op_b = imm_q;
      B_SHAMT: bus.out_op_b = XLEN'(shamt_q);
      default: bus.out_op_b = rs2_fwd;
    endcase
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = v_q && !stall;
  assign bus.hazard_stall = stall;
  assign bus.out_rs2_data = rs2_fwd;
  assign bus.out_rd       = rd_q;
  assign bus.out_we       = we_q;
  assign bus.out_imm      = imm_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_ctrl     = ctrl_q;

endmodule
